// File: rtl/key_frontend_if.sv
// Bundle of raw front-panel buttons and the conditioned mode/pulse outputs
// exchanged between key_frontend (slave) and the controller or bench (master).
interface key_frontend_if;
    logic       key_mode;
    logic       key_plus;
    logic       key_sub;
    logic [1:0] mode;
    logic       plus_pulse;
    logic       sub_pulse;
    logic       mode_pulse;

    modport master (
        output key_mode, key_plus, key_sub,
        input  mode, plus_pulse, sub_pulse, mode_pulse
    );

    modport slave (
        input  key_mode, key_plus, key_sub,
        output mode, plus_pulse, sub_pulse, mode_pulse
    );
endinterface

// File: rtl/key_frontend.sv
// Button front end: sync, 1 ms-tick debounce, mode FSM and gated plus/sub pulses.
// Optional hold auto-repeat on plus/sub is enabled by defining KEY_AUTOREPEAT_EN.
module key_frontend #(
    parameter int CLK_HZ      = 12_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 600,
    parameter int REPEAT_MS   = 150,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    key_frontend_if.slave  bus
);

    localparam int               DIV      = CLK_HZ / 1000;
    localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [15:0]      DEB_LIM  = 16'(DEBOUNCE_MS);
    localparam logic [15:0]      SAT      = 16'hFFFF;
    localparam logic             RELEASED = (ACTIVE_LOW != 0);
    localparam int               K_MODE   = 0;
    localparam int               K_PLUS   = 1;
    localparam int               K_SUB    = 2;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        NIGHT  = 2'b01,
        SET_RG = 2'b10,
        SET_Y  = 2'b11
    } mode_t;

    logic [2:0]       raw, sync1, sync2, pressed;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [15:0]      deb_cnt [3];
    logic [2:0]       level, accept, rise;
    mode_t            state_q, state_d;
    logic             mode_change;
    logic [1:0]       rep_ok;
    logic             plus_any, sub_any, plus_fwd, sub_fwd;
    logic             plus_q, sub_q, mode_pulse_q;

    assign raw = {bus.key_sub, bus.key_plus, bus.key_mode};

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, which is what makes sync1 -> sync2 a real two-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= {3{RELEASED}};
            sync2 <= {3{RELEASED}};
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ {3{RELEASED}};

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // Acceptance is checked on the tick after the counter already holds the limit,
    // so a disagreement must span DEBOUNCE_MS+1 ticks before the level flips.
    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        accept = '0;
        for (int k = 0; k < 3; k++)
            accept[k] = tick && (pressed[k] != level[k]) && (deb_cnt[k] == DEB_LIM);
    end

    assign rise = accept & pressed;

    // NOTE: the small counter array is reset element by element; it is state that
    // must start at zero, not a RAM, so a reset loop is appropriate here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (pressed[k] == level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (accept[k]) begin
                    level[k]   <= pressed[k];
                    deb_cnt[k] <= '0;
                end else if (tick && deb_cnt[k] != SAT) begin
                    deb_cnt[k] <= deb_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign mode_change = rise[K_MODE];

    always_comb begin
        state_d = state_q;
        if (mode_change) begin
            case (state_q)
                RUN:     state_d = NIGHT;
                NIGHT:   state_d = SET_RG;
                SET_RG:  state_d = SET_Y;
                default: state_d = RUN;
            endcase
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [15:0] LONG_LIM = 16'(LONG_MS);
    localparam logic [15:0] REP_LAST = 16'(REPEAT_MS - 1);

    // Index 0 is plus, 1 is sub; blk kills repeats of a press that was discarded
    // or that lived through a mode change, until the key is released.
    logic [15:0] hold_cnt [2];
    logic [15:0] rep_cnt  [2];
    logic [1:0]  rep_fire, blk;

    always_comb begin
        rep_fire = '0;
        for (int j = 0; j < 2; j++) begin
            if (tick && level[j+1]) begin
                if (hold_cnt[j] != SAT && (hold_cnt[j] + 16'd1) == LONG_LIM)
                    rep_fire[j] = 1'b1;
                else if (hold_cnt[j] >= LONG_LIM && rep_cnt[j] == REP_LAST)
                    rep_fire[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk <= '0;
            for (int j = 0; j < 2; j++) begin
                hold_cnt[j] <= '0;
                rep_cnt[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!level[j+1]) begin
                    hold_cnt[j] <= '0;
                    rep_cnt[j]  <= '0;
                end else if (tick) begin
                    if (hold_cnt[j] != SAT) hold_cnt[j] <= hold_cnt[j] + 16'd1;
                    if (rep_fire[j])
                        rep_cnt[j] <= '0;
                    else if (hold_cnt[j] >= LONG_LIM && rep_cnt[j] != SAT)
                        rep_cnt[j] <= rep_cnt[j] + 16'd1;
                end

                if (rise[j+1])
                    blk[j] <= rise[2-j] | level[2-j] | mode_change;
                else if (!level[j+1])
                    blk[j] <= 1'b0;
                else if (mode_change)
                    blk[j] <= 1'b1;
            end
        end
    end

    assign rep_ok = rep_fire & ~blk;
`else
    assign rep_ok = 2'b00;
`endif

    assign plus_any = (rise[K_PLUS] & ~level[K_SUB])  | rep_ok[0];
    assign sub_any  = (rise[K_SUB]  & ~level[K_PLUS]) | rep_ok[1];
    assign plus_fwd = state_q[1] & plus_any & ~sub_any;
    assign sub_fwd  = state_q[1] & sub_any  & ~plus_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            mode_pulse_q <= 1'b0;
            plus_q       <= 1'b0;
            sub_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_pulse_q <= mode_change;
            plus_q       <= plus_fwd;
            sub_q        <= sub_fwd;
        end
    end

    assign bus.mode       = state_q;
    assign bus.mode_pulse = mode_pulse_q;
    assign bus.plus_pulse = plus_q;
    assign bus.sub_pulse  = sub_q;

endmodule

// File: tb/tb_key_frontend.sv
// Scoreboard bench for key_frontend at a 10 kHz clock (1 tick = 10 clk).
// Expected pulses are queued as stimulus is driven and popped when the DUT pulses.
module tb_key_frontend;

    localparam int MAX_LAT = 43;
    localparam int K_MODE  = 1;
    localparam int K_PLUS  = 2;
    localparam int K_SUB   = 3;

    typedef struct {
        int kind;
        int mode;
        int gap;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mode_cur = 0;
    int   press_cyc [4];
    int   last_cyc  [4];
    exp_t sb [$];

    key_frontend_if bus ();

    key_frontend #(
        .CLK_HZ      (10_000),
        .DEBOUNCE_MS (3),
        .LONG_MS     (20),
        .REPEAT_MS   (5),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int kind, input int mode, input int gap, input int lat);
        exp_t e;
        e.kind = kind;
        e.mode = mode;
        e.gap  = gap;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic handle(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected", kind, 0);
        end else begin
            e = sb.pop_front();
            check("sb_kind", kind, e.kind);
            check("sb_mode", {30'd0, bus.mode}, e.mode);
            if (e.gap >= 0) check("sb_gap", cyc - last_cyc[kind], e.gap);
            if (e.lat >= 0) check("sb_latency_ok", (cyc - press_cyc[kind] <= e.lat) ? 1 : 0, 1);
        end
        last_cyc[kind] = cyc;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.mode_pulse) handle(K_MODE);
            if (bus.plus_pulse) handle(K_PLUS);
            if (bus.sub_pulse)  handle(K_SUB);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key_set(input int k, input logic v);
        case (k)
            K_MODE:  bus.key_mode = v;
            K_PLUS:  bus.key_plus = v;
            default: bus.key_sub  = v;
        endcase
        if (!v) press_cyc[k] = cyc;
    endtask

    task automatic press(input int k, input int hold);
        key_set(k, 1'b0);
        idle(hold);
        key_set(k, 1'b1);
    endtask

    task automatic mode_press();
        mode_cur = (mode_cur + 1) % 4;
        expect_pulse(K_MODE, mode_cur, -1, MAX_LAT);
        press(K_MODE, 100);
        idle(100);
    endtask

    task automatic drain(input string tag);
        idle(100);
        check(tag, sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mode"}, {30'd0, bus.mode}, 0);
        check({tag, "_plus"}, {31'd0, bus.plus_pulse}, 0);
        check({tag, "_sub"},  {31'd0, bus.sub_pulse}, 0);
        check({tag, "_mpls"}, {31'd0, bus.mode_pulse}, 0);
    endtask

    initial begin
        rst_n        = 1'b1;
        bus.key_mode = 1'b1;
        bus.key_plus = 1'b1;
        bus.key_sub  = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("init_rst");
        idle(5);
        rst_n = 1'b1;
        idle(200);
        drain("init_quiet");

        // Mode cycling RUN -> NIGHT -> SET_RG -> SET_Y -> RUN.
        repeat (4) mode_press();
        drain("mode_cycle");

        // Plus ignored in RUN.
        press(K_PLUS, 100);
        idle(100);
        drain("gate_run");

        repeat (2) mode_press();
        drain("to_set_rg");

        // Glitches shorter than the debounce window.
        repeat (5) begin
            press(K_PLUS, 25);
            idle(50);
        end
        drain("glitch");

        // Long hold in SET_RG.
        expect_pulse(K_PLUS, 2, -1, MAX_LAT);
`ifdef KEY_AUTOREPEAT_EN
        expect_pulse(K_PLUS, 2, 200, -1);
        repeat (3) expect_pulse(K_PLUS, 2, 50, -1);
`endif
        press(K_PLUS, 375);
        idle(150);
        drain("autorepeat");

        mode_press();
        drain("to_set_y");

        // Simultaneous plus and sub are both dropped.
        key_set(K_PLUS, 1'b0);
        key_set(K_SUB, 1'b0);
        idle(100);
        key_set(K_PLUS, 1'b1);
        key_set(K_SUB, 1'b1);
        idle(100);
        drain("simultaneous");

        expect_pulse(K_SUB, 3, -1, MAX_LAT);
        press(K_SUB, 100);
        idle(100);
        drain("sub_alone");

        repeat (3) mode_press();
        drain("back_to_set_rg");

        // Mode press during a repeating plus hold stops the repeats.
        expect_pulse(K_PLUS, 2, -1, MAX_LAT);
`ifdef KEY_AUTOREPEAT_EN
        expect_pulse(K_PLUS, 2, 200, -1);
`endif
        mode_cur = 3;
        expect_pulse(K_MODE, 3, -1, MAX_LAT);
        key_set(K_PLUS, 1'b0);
        idle(225);
        key_set(K_MODE, 1'b0);
        idle(100);
        key_set(K_MODE, 1'b1);
        idle(275);
        key_set(K_PLUS, 1'b1);
        idle(100);
        drain("mode_cancels_repeat");

        expect_pulse(K_PLUS, 3, -1, MAX_LAT);
        press(K_PLUS, 100);
        idle(100);
        drain("repress_after_cancel");

        // Asynchronous reset mid-stream with mode at SET_Y.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        idle(5);
        rst_n    = 1'b1;
        mode_cur = 0;
        idle(200);
        drain("post_reset_quiet");

        // Mode key held through reset release yields exactly one press.
        rst_n = 1'b0;
        key_set(K_MODE, 1'b0);
        idle(20);
        expect_pulse(K_MODE, 1, -1, -1);
        rst_n = 1'b1;
        idle(150);
        key_set(K_MODE, 1'b1);
        idle(100);
        drain("reset_held_key");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
